// File: rtl/ordener_collector.sv
// ordener_collector: packs a serial valid/ready byte stream into 8-slot frames for the ordener2 sorter.
// Optional min/max outputs are enabled by defining ORDENER_COLLECT_MINMAX_EN.
`default_nettype none

module ordener_collector #(
  parameter int                 DATA_W    = 8,
  parameter logic [DATA_W-1:0]  PAD_VALUE = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic [DATA_W-1:0] out_d,
  output logic [DATA_W-1:0] out_e,
  output logic [DATA_W-1:0] out_f,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_h,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_pad_cnt,
`ifdef ORDENER_COLLECT_MINMAX_EN
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
`endif
  output logic [15:0]       frame_cnt
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [2:0]        idx;
  logic [3:0]        pad_cnt;
  logic [DATA_W-1:0] slot [8];

  logic       hs;
  logic [3:0] occupied;
  logic       full;
  logic       flush_eff;
  logic       close;

  assign hs        = in_valid && in_ready;
  assign occupied  = {1'b0, idx} + {3'b000, hs};
  assign full      = hs && (idx == 3'd7);
  assign flush_eff = flush && (state == FILL) && (occupied != 4'd0);
  assign close     = (state == FILL) && (full || flush_eff);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (full || flush_eff) state_nxt = HOLD;
      HOLD:    if (out_ready)         state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Handshake outputs come from registered state only; rst forces in_ready low.
  always_comb begin
    in_ready  = (state == FILL) && !rst;
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= 3'd0;
      pad_cnt   <= 4'd0;
      frame_cnt <= 16'd0;
    end else begin
      if (close) begin
        idx     <= 3'd0;
        pad_cnt <= full ? 4'd0 : (4'd8 - occupied);
      end else if (hs) begin
        idx <= idx + 3'd1;
      end
      if (out_valid && out_ready) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // A same-cycle sample lands in slot idx; padding starts just above it.
  for (genvar i = 0; i < 8; i++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst)                                  slot[i] <= '0;
      else if (hs && (idx == 3'(i)))            slot[i] <= in_data;
      else if (flush_eff && (4'(i) >= occupied)) slot[i] <= PAD_VALUE;
    end
  end

  assign out_a       = slot[0];
  assign out_b       = slot[1];
  assign out_c       = slot[2];
  assign out_d       = slot[3];
  assign out_e       = slot[4];
  assign out_f       = slot[5];
  assign out_g       = slot[6];
  assign out_h       = slot[7];
  assign out_pad_cnt = pad_cnt;

`ifdef ORDENER_COLLECT_MINMAX_EN
  logic [DATA_W-1:0] run_min;
  logic [DATA_W-1:0] run_max;
  logic [DATA_W-1:0] min_nxt;
  logic [DATA_W-1:0] max_nxt;

  // The first sample of a frame reseeds the running extremes.
  always_comb begin
    min_nxt = run_min;
    max_nxt = run_max;
    if (hs) begin
      if (idx == 3'd0) begin
        min_nxt = in_data;
        max_nxt = in_data;
      end else begin
        min_nxt = (in_data < run_min) ? in_data : run_min;
        max_nxt = (in_data > run_max) ? in_data : run_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min <= '0;
      run_max <= '0;
      out_min <= '0;
      out_max <= '0;
    end else begin
      if (hs) begin
        run_min <= min_nxt;
        run_max <= max_nxt;
      end
      if (close) begin
        out_min <= min_nxt;
        out_max <= max_nxt;
      end
    end
  end
`endif

endmodule

`default_nettype wire
